// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: register map, STATUS layout, drain states.
package uart_fifo_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned ST_NOTFULL = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_TXRDY   = 3;
  localparam int unsigned ST_LVL_LSB = 8;

  typedef enum logic {IDLE, HOLD} drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous register-array FIFO with asynchronous head read and an explicit occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_cpu,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      mem   <= '{default: '0};
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped transmit buffer: bus decode, sticky overflow flag and the drain FSM feeding uart_tx.
module uart_tx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk_cpu,
  input  logic        n_reset,
  input  logic        bus_valid,
  input  logic        bus_addr,
  input  logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        irq_empty
);

  logic                   accepted;
  logic                   wr_data;
  logic                   wr_status;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [LVL_W-1:0]       level;
  logic                   ovf;
  logic [31:0]            status;
  drain_state_t           state;
  logic                   unused_bits;

  assign accepted  = bus_valid && bus_ready;
  assign wr_data   = accepted && (bus_addr == REG_DATA) && bus_wstrb[0];
  assign wr_status = accepted && (bus_addr == REG_STATUS) && bus_wstrb[0];
  assign push      = wr_data && !full;
  assign level     = LVL_W'(fifo_level);

  // The strobe is decoded from the state register so a byte pushed in cycle N
  // reaches uart_tx in cycle N+1; HOLD enforces the one-cycle gap.
  assign tx_data_valid = (state == IDLE) && !empty && tx_data_ready;
  assign pop           = tx_data_valid;

  assign unused_bits = ^{bus_wstrb[3:1], bus_wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_cpu (clk_cpu),
    .n_reset (n_reset),
    .push    (push),
    .pop     (pop),
    .wdata   (bus_wdata[7:0]),
    .rdata   (tx_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    status                     = '0;
    status[ST_NOTFULL]         = !full;
    status[ST_EMPTY]           = empty;
    status[ST_OVF]             = ovf;
    status[ST_TXRDY]           = tx_data_ready;
    status[ST_LVL_LSB +: 8]    = 8'(level);
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      ovf       <= 1'b0;
      irq_empty <= 1'b0;
    end else begin
      bus_ready <= bus_valid && !bus_ready;
      if (bus_valid && !bus_ready) begin
        bus_rdata <= status;
      end
      if (wr_data && full) begin
        ovf <= 1'b1;
      end else if (wr_status && bus_wdata[ST_OVF]) begin
        ovf <= 1'b0;
      end
      irq_empty <= empty && tx_data_ready;
    end
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (tx_data_valid) state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed/random bench for uart_tx_fifo against a queue-based reference of the transmit buffer.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk_cpu = 1'b0;
  logic        n_reset;
  logic        bus_valid;
  logic        bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        irq_empty;

  int checks   = 0;
  int failures = 0;

  byte unsigned q[$];
  byte unsigned sent[$];
  byte unsigned rcvd[$];
  logic         m_ovf;
  logic         m_accept;
  int           cyc;
  int           last_pulse;
  int           first_pulse;
  int           pulse_cnt;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_cpu       (clk_cpu),
    .n_reset       (n_reset),
    .bus_valid     (bus_valid),
    .bus_addr      (bus_addr),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ready     (bus_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .irq_empty     (irq_empty)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (q.size() != DEPTH);
    s[1]     = (q.size() == 0);
    s[2]     = m_ovf;
    s[3]     = tx_data_ready;
    s[15:8]  = 8'(q.size());
    return s;
  endfunction

  // One clock cycle: check outputs mid-cycle, advance the reference, end at posedge+1.
  task automatic step();
    logic exp_valid;
    logic irq_next;
    logic popped;
    logic pushed;
    @(negedge clk_cpu);
    exp_valid = tx_data_ready && (q.size() != 0) && (cyc - last_pulse >= 2);
    chk("tx_valid", 32'(tx_data_valid), 32'(exp_valid));
    popped = 1'b0;
    pushed = 1'b0;
    if (tx_data_valid === 1'b1 && q.size() != 0) begin
      chk("tx_data", 32'(tx_data), 32'(q[0]));
      rcvd.push_back(tx_data);
      last_pulse = cyc;
      pulse_cnt++;
      if (pulse_cnt == 1) first_pulse = cyc;
      popped = 1'b1;
    end
    irq_next = (q.size() == 0) && tx_data_ready;
    if (m_accept) begin
      if (bus_addr == 1'b0 && bus_wstrb[0]) begin
        if (q.size() >= DEPTH) m_ovf = 1'b1;
        else pushed = 1'b1;
      end else if (bus_addr == 1'b1 && bus_wstrb[0] && bus_wdata[2]) begin
        m_ovf = 1'b0;
      end
    end
    if (popped) void'(q.pop_front());
    if (pushed) q.push_back(bus_wdata[7:0]);
    @(posedge clk_cpu);
    #1;
    cyc++;
    chk("irq_empty", 32'(irq_empty), 32'(irq_next));
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    bus_valid = 1'b1;
    bus_addr  = a;
    bus_wstrb = 4'h1;
    bus_wdata = d;
    step();
    chk("bus_ready_wr", 32'(bus_ready), 32'd1);
    m_accept = 1'b1;
    step();
    m_accept  = 1'b0;
    chk("bus_ready_drop", 32'(bus_ready), 32'd0);
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] rd);
    logic [31:0] exp;
    bus_valid = 1'b1;
    bus_addr  = a;
    bus_wstrb = 4'h0;
    bus_wdata = $urandom;
    exp = model_status();
    step();
    chk("bus_ready_rd", 32'(bus_ready), 32'd1);
    chk("rdata", bus_rdata, exp);
    rd = bus_rdata;
    m_accept = 1'b1;
    step();
    m_accept  = 1'b0;
    bus_valid = 1'b0;
  endtask

  initial begin
    logic [31:0]  rd;
    byte unsigned b;
    int           guard;

    n_reset       = 1'b0;
    bus_valid     = 1'b0;
    bus_addr      = 1'b0;
    bus_wstrb     = 4'h0;
    bus_wdata     = '0;
    tx_data_ready = 1'b0;
    m_ovf         = 1'b0;
    m_accept      = 1'b0;
    cyc           = 0;
    last_pulse    = -10;
    first_pulse   = 0;
    pulse_cnt     = 0;

    repeat (2) @(posedge clk_cpu);
    #1;
    chk("rst_bus_ready", 32'(bus_ready), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_irq", 32'(irq_empty), 32'd0);
    n_reset = 1'b1;

    // Basic send
    tx_data_ready = 1'b1;
    step();
    step();
    chk("irq_idle", 32'(irq_empty), 32'd1);
    bus_write(1'b0, 32'h0000_0041);
    chk("basic_valid", 32'(tx_data_valid), 32'd1);
    chk("basic_data", 32'(tx_data), 32'h41);
    step();
    chk("basic_hold", 32'(tx_data_valid), 32'd0);
    bus_read(1'b1, rd);
    chk("basic_status", rd, 32'h0000_000B);

    // Fill without draining, then overflow
    tx_data_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(1'b0, 32'(i));
    bus_read(1'b1, rd);
    chk("fill_status", rd, 32'h0000_1000);
    bus_write(1'b0, 32'h0000_00A5);
    bus_read(1'b1, rd);
    chk("ovf_status", rd, 32'h0000_1004);
    tx_data_ready = 1'b1;
    pulse_cnt = 0;
    rcvd.delete();
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    chk("drain_count", 32'(pulse_cnt), 32'd16);
    chk("drain_span", 32'(last_pulse - first_pulse), 32'd30);
    if (rcvd.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("drain_order", 32'(rcvd[i]), 32'(i));
    end

    // Overflow clear
    bus_read(1'b1, rd);
    chk("ovf_still_set", 32'(rd[2]), 32'd1);
    bus_write(1'b1, 32'h0000_0004);
    bus_read(1'b1, rd);
    chk("ovf_clr", 32'(rd[2]), 32'd0);

    // Wrap-around with random ready
    sent.delete();
    rcvd.delete();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      guard = 0;
      while (q.size() >= DEPTH && guard < 100) begin
        tx_data_ready = 1'($urandom_range(0, 1));
        step();
        guard++;
      end
      chk("wrap_wait", 32'(guard < 100), 32'd1);
      tx_data_ready = 1'($urandom_range(0, 1));
      sent.push_back(b);
      bus_write(1'b0, 32'(b) | ($urandom & 32'hFFFF_FF00));
      if (n % 8 == 7) begin
        bus_read(1'b1, rd);
        chk("wrap_lvl_le16", 32'(rd[15:8] <= 8'd16), 32'd1);
      end
    end
    tx_data_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    chk("wrap_count", 32'(rcvd.size()), 32'd40);
    if (rcvd.size() == 40) begin
      for (int i = 0; i < 40; i++) chk("wrap_order", 32'(rcvd[i]), 32'(sent[i]));
    end

    // Push at full coinciding with a pop
    tx_data_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(1'b0, 32'(8'hC0 + i));
    bus_valid = 1'b1;
    bus_addr  = 1'b0;
    bus_wstrb = 4'h1;
    bus_wdata = 32'h0000_00EE;
    step();
    chk("sim_ready", 32'(bus_ready), 32'd1);
    tx_data_ready = 1'b1;
    m_accept = 1'b1;
    step();
    m_accept      = 1'b0;
    bus_valid     = 1'b0;
    bus_wstrb     = 4'h0;
    tx_data_ready = 1'b0;
    bus_read(1'b1, rd);
    chk("sim_status", rd, 32'h0000_0F05);
    bus_write(1'b1, 32'h0000_0004);
    rcvd.delete();
    tx_data_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    chk("sim_drain", 32'(rcvd.size()), 32'd15);

    // Reset mid-operation
    tx_data_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(1'b0, 32'($urandom_range(0, 255)));
    bus_read(1'b1, rd);
    chk("pre_rst_lvl", 32'(rd[15:8]), 32'd5);
    bus_valid = 1'b1;
    bus_addr  = 1'b1;
    bus_wstrb = 4'h0;
    step();
    tx_data_ready = 1'b1;
    #1;
    chk("pre_rst_valid", 32'(tx_data_valid), 32'd1);
    chk("pre_rst_ready", 32'(bus_ready), 32'd1);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_bus_ready", 32'(bus_ready), 32'd0);
    chk("mid_rst_rdata", bus_rdata, 32'd0);
    chk("mid_rst_valid", 32'(tx_data_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_irq", 32'(irq_empty), 32'd0);
    bus_valid     = 1'b0;
    tx_data_ready = 1'b0;
    q.delete();
    m_ovf      = 1'b0;
    last_pulse = cyc - 10;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    n_reset = 1'b1;
    @(posedge clk_cpu);
    #1;
    bus_read(1'b1, rd);
    chk("post_rst_status", rd, 32'h0000_0003);
    tx_data_ready = 1'b1;
    pulse_cnt = 0;
    repeat (6) step();
    chk("post_rst_no_pulse", 32'(pulse_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Memory-mapped transmit buffer between the picorv32 peripheral bus and `uart_tx`. Software writes bytes at bus speed into a DEPTH-entry FIFO, and a drain FSM feeds them to `uart_tx` through its valid/ready pair. The CPU stalls only when it chooses to poll a full buffer, not on every character. It occupies the UART address window (`0xff00_0000`). Status bit 0 keeps the existing "can accept a byte" meaning, so existing polling firmware still works.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries. Must be a power of 2 and ≥ 2.
- `LVL_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk_cpu`  in  1: clock.
- `n_reset`  in  1: asynchronous, active-low reset.
- `bus_valid`  in  1: `mem_valid` qualified with the UART address decode.
- `bus_addr`  in  1: `mem_addr[2]`. 0 = DATA, 1 = STATUS.
- `bus_wstrb`  in  4: `mem_wstrb`. Only bit 0 is used.
- `bus_wdata`  in  32: `mem_wdata`.
- `bus_rdata`  out  32: read data.
- `bus_ready`  out  1: transaction acknowledge.
- `tx_data`  out  8: byte presented to `uart_tx`.
- `tx_data_valid`  out  1: one-cycle transfer strobe to `uart_tx`.
- `tx_data_ready`  in  1: `uart_tx` is idle and can accept a byte.
- `irq_empty`  out  1: level. High while the FIFO is empty and `tx_data_ready` is high.

## Operation
- **Bus acknowledge:**
  - `bus_ready` is registered: `bus_ready <= bus_valid && !bus_ready`. This gives one ready cycle per access.
  - A transaction is *accepted* in the cycle where `bus_valid && bus_ready`. All side effects happen only on the accepted cycle.
- **Write DATA** (`bus_addr`=0, `bus_wstrb[0]`=1):
  - If not full, push `bus_wdata[7:0]`.
  - If full, drop the byte and set sticky `ovf`.
- **Write STATUS** (`bus_addr`=1, `bus_wstrb[0]`=1): `bus_wdata[2]`=1 clears `ovf`. All other bits are ignored.
- **Read** (any address), `bus_rdata` fields:
  - `[0]` = !full
  - `[1]` = empty
  - `[2]` = `ovf`
  - `[3]` = `tx_data_ready`
  - `[15:8]` = level, zero-extended
  - all other bits 0
  - Reads have no side effects.
- **Drain FSM** (states IDLE, HOLD):
  - IDLE: when `!empty && tx_data_ready`, assert `tx_data_valid`, pop the FIFO and go to HOLD.
  - HOLD: `tx_data_valid` is 0. Return to IDLE unconditionally after 1 cycle. This covers `uart_tx` dropping `tx_data_ready` one cycle late.
- `tx_data` always shows the FIFO head. It is valid whenever `tx_data_valid`=1.
- **Level arithmetic:**
  - level counts 0..DEPTH.
  - full = (level == DEPTH); empty = (level == 0).
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Simultaneous push and pop:**
  - Full-check uses level *before* the pop, so a push while full is dropped (`ovf` set) even if a pop happens in the same cycle.
  - Push and pop together leave level unchanged.
- **Empty bypass:** none. A pushed byte is poppable no earlier than the next cycle.

## Timing
- **Reset values:**
  - `bus_ready`=0, `bus_rdata`=0, `tx_data_valid`=0, `tx_data`=0, `irq_empty`=0.
  - level=0, pointers=0, `ovf`=0, FSM=IDLE.
  - Reset mid-transfer discards all queued bytes. A `tx_data_valid` pulse in progress is cut off.
- **Bus latency:** `bus_ready` rises 1 cycle after `bus_valid`. `bus_rdata` is valid in the same cycle as `bus_ready` and is registered from the pre-access state.
- **Push to transmit:** with the FIFO empty and `tx_data_ready`=1, `tx_data_valid` pulses 1 cycle after the accepted write.
- **Back-to-back:** `tx_data_valid` pulses at most once every 2 cycles.
- **STATUS timing:** level and flags update on the clock edge after an accepted push or pop. A STATUS read in that same cycle returns the old value.

## Structure
- Package `uart_fifo_pkg` holds:
  - `localparam` register offsets `REG_DATA`=0, `REG_STATUS`=1.
  - STATUS bit indices `ST_NOTFULL`, `ST_EMPTY`, `ST_OVF`, `ST_TXRDY`, `ST_LVL_LSB`.
  - `typedef enum logic {IDLE, HOLD} drain_state_t`.
- Sub-module `sync_fifo`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: `push`, `pop`, `wdata`, `rdata` (head), `full`, `empty`, `level`.
  - Register-array storage with asynchronous head read.
- The top level contains the bus decode, the `ovf` flag and the drain FSM. `soc_top` instantiates it between the bus and `uart_tx`.

## Test plan
- **Basic send:** write DATA 0x41, `tx_data_ready`=1. Required: `bus_ready` 1 cycle later, then `tx_data_valid` for 1 cycle with `tx_data`=0x41, then level returns to 0.
- **Fill without draining:** hold `tx_data_ready`=0 and write 16 bytes 0x00..0x0F. Read STATUS = 0x0000_1000 (level 16, full, `ovf`=0). A 17th write sets `ovf`, and STATUS reads 0x0000_1004. Release ready: exactly 0x00..0x0F are emitted in order, each pulse 2 cycles apart.
- **Overflow clear:** with `ovf`=1, write STATUS with `wdata`=0x4. The next STATUS read has bit 2 = 0.
- **Wrap-around:** stream 40 bytes while `tx_data_ready` toggles with a pseudo-random pattern. Required: output sequence equals input sequence, and level never exceeds 16.
- **Simultaneous push and pop:** at full, an accepted write lands in the same cycle as a pop. Required: byte dropped, `ovf`=1, level=15 afterward.
- **Reset mid-operation:** with level=5, assert `n_reset` low asynchronously. Required: outputs take their reset values immediately. After release, STATUS reads 0x0000_0003 (!full and empty; `tx_data_ready`=0 during the read) and no `tx_data_valid` pulse occurs.
